// File: rtl/fifo_wr_packer.sv
// Write-side packer: gathers IN_WIDTH lanes LSB-first into DATA_WIDTH words and feeds an async FIFO.
// Define WR_PACKER_TIMEOUT_EN to build the idle auto-flush counter (TIMEOUT cycles).
module fifo_wr_packer #(
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  full,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
);

  localparam int unsigned Ratio = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

  if ((DATA_WIDTH % IN_WIDTH) != 0 || Ratio < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_wr_packer: DATA_WIDTH must be a multiple (>=2) of IN_WIDTH, TIMEOUT >= 1");
  end

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]       lane_cnt_q, lane_cnt_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_vld_q, hold_vld_d;

  logic                  hold_free;
  logic                  accept;
  logic                  lane_done;
  logic                  flush;
  logic                  complete;
  logic [DATA_WIDTH-1:0] acc_lane;
  logic [DATA_WIDTH-1:0] word;

  assign hold_free = ~hold_vld_q | ~full;
  assign accept    = s_valid & s_ready;
  assign lane_done = accept & (s_last | (lane_cnt_q == LastLane));
  assign complete  = lane_done | flush;

  // Upper lanes of acc are always zero past lane_cnt, so a flushed word is already zero-filled.
  always_comb begin
    acc_lane = acc_q;
    acc_lane[lane_cnt_q*IN_WIDTH +: IN_WIDTH] = s_data;
  end

  assign word = lane_done ? acc_lane : acc_q;

`ifdef WR_PACKER_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT - 1);

  logic [TmrW-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_flush;

  // Counter saturates at TmrMax while the hold register is blocked.
  always_comb begin
    timeout_flush = (state_q == StFill) && !accept && (idle_cnt_q == TmrMax) && hold_free;
    idle_cnt_d    = idle_cnt_q;
    if (accept || (state_q != StFill) || timeout_flush) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TmrMax) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign flush = timeout_flush;
`else
  assign flush = 1'b0;
`endif

  // State register.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !lane_done) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (complete) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    s_ready = wrst_n & hold_free;
    winc    = wrst_n & hold_vld_q & ~full;
    wdata   = wrst_n ? hold_data_q : '0;
    busy    = wrst_n & (hold_vld_q | (state_q == StFill));
  end

  // Accumulator and hold register datapath.
  always_comb begin
    acc_d       = acc_q;
    lane_cnt_d  = lane_cnt_q;
    hold_data_d = hold_data_q;
    hold_vld_d  = hold_vld_q;
    if (complete) begin
      acc_d       = '0;
      lane_cnt_d  = '0;
      hold_data_d = word;
      hold_vld_d  = 1'b1;
    end else begin
      if (accept) begin
        acc_d      = acc_lane;
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
      if (winc) begin
        hold_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      acc_q       <= '0;
      lane_cnt_q  <= '0;
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lane_cnt_q  <= lane_cnt_d;
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: directed scenarios plus random traffic against a lane-queue packing model.
module tb_fifo_wr_packer;

  localparam int unsigned InW   = 8;
  localparam int unsigned DataW = 32;
  localparam int unsigned Ratio = DataW / InW;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic             s_valid;
  logic             s_ready;
  logic [InW-1:0]   s_data;
  logic             s_last;
  logic             full;
  logic             winc;
  logic [DataW-1:0] wdata;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic             obs_ready;
  logic             obs_winc;
  logic             obs_busy;
  logic [DataW-1:0] obs_wdata;

  logic [InW-1:0]   cur_q[$];
  logic [DataW-1:0] exp_q[$];
  logic [DataW-1:0] word;

  always #5 wclk = ~wclk;

  fifo_wr_packer #(
    .IN_WIDTH  (InW),
    .DATA_WIDTH(DataW),
    .TIMEOUT   (16)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .full   (full),
    .winc   (winc),
    .wdata  (wdata),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [DataW-1:0] got,
                       input logic [DataW-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    @(negedge wclk);
    obs_ready = s_ready;
    obs_winc  = winc;
    obs_busy  = busy;
    obs_wdata = wdata;
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input logic [InW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    step();
  endtask

  initial begin
    wrst_n  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    full    = 1'b0;
    @(posedge wclk);
    #1;

    // Reset state
    step();
    check("rst_ready", obs_ready, 0);
    check("rst_winc", obs_winc, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_wdata", obs_wdata, 0);
    wrst_n = 1'b1;

    // Back-to-back full word
    for (int i = 0; i < 4; i++) begin
      send(8'((i + 1) * 'h11), 1'b0);
      check("b2b_ready", obs_ready, 1);
      check("b2b_no_early_winc", obs_winc, 0);
    end
    idle();
    check("b2b_winc", obs_winc, 1);
    check("b2b_wdata", obs_wdata, 32'h4433_2211);
    idle();
    check("b2b_single_pulse", obs_winc, 0);
    check("b2b_busy_clear", obs_busy, 0);

    // Partial flush via s_last
    send(8'hAA, 1'b0);
    check("part_busy", obs_busy, 0);
    send(8'hBB, 1'b1);
    check("part_busy_fill", obs_busy, 1);
    idle();
    check("part_winc", obs_winc, 1);
    check("part_wdata", obs_wdata, 32'h0000_BBAA);
    idle();
    check("part_winc_done", obs_winc, 0);
    check("part_busy_after", obs_busy, 0);

    // Sustained throughput
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), 1'b0);
      check("sus_ready", obs_ready, 1);
      check("sus_winc", obs_winc, (i == 4));
      if (i == 4) check("sus_wdata0", obs_wdata, 32'h0403_0201);
    end
    idle();
    check("sus_winc1", obs_winc, 1);
    check("sus_wdata1", obs_wdata, 32'h0807_0605);
    idle();
    check("sus_winc_done", obs_winc, 0);

    // s_last on the final lane gives a normal word, no extra write
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), (i == 3));
    idle();
    check("last3_winc", obs_winc, 1);
    check("last3_wdata", obs_wdata, 32'hC3C2_C1C0);
    idle();
    check("last3_no_extra", obs_winc, 0);
    check("last3_busy", obs_busy, 0);

    // s_last on lane 0
    send(8'h7E, 1'b1);
    idle();
    check("last0_winc", obs_winc, 1);
    check("last0_wdata", obs_wdata, 32'h0000_007E);
    idle();
    check("last0_done", obs_winc, 0);

    // Backpressure: word held while full, released the cycle full drops
    full = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    check("bp_fill_ready", obs_ready, 1);
    s_valid = 1'b1;
    s_data  = 8'h99;
    s_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_stall_ready", obs_ready, 0);
      check("bp_stall_winc", obs_winc, 0);
      check("bp_stall_hold", obs_wdata, 32'hDDCC_BBAA);
      check("bp_stall_busy", obs_busy, 1);
    end
    full = 1'b0;
    step();
    check("bp_release_winc", obs_winc, 1);
    check("bp_release_wdata", obs_wdata, 32'hDDCC_BBAA);
    check("bp_release_ready", obs_ready, 1);
    idle();
    check("bp_reload_winc", obs_winc, 1);
    check("bp_reload_wdata", obs_wdata, 32'h0000_0099);
    idle();
    check("bp_end_winc", obs_winc, 0);
    check("bp_end_busy", obs_busy, 0);

    // Reset mid-word discards partial lanes
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    wrst_n  = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h33;
    step();
    check("rmid_winc", obs_winc, 0);
    check("rmid_busy", obs_busy, 0);
    check("rmid_ready", obs_ready, 0);
    wrst_n = 1'b1;
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    idle();
    check("rmid_winc_after", obs_winc, 1);
    check("rmid_wdata", obs_wdata, 32'h8877_6655);
    idle();

    // Reset mid-stall discards the held word
    full = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hF0 + 8'(i), 1'b0);
    s_valid = 1'b0;
    wrst_n  = 1'b0;
    step();
    check("rstall_winc", obs_winc, 0);
    check("rstall_wdata", obs_wdata, 0);
    check("rstall_busy", obs_busy, 0);
    wrst_n = 1'b1;
    full   = 1'b0;
    idle();
    check("rstall_discard", obs_winc, 0);
    check("rstall_busy_after", obs_busy, 0);

    // Idle behaviour after a single lane
    send(8'h5A, 1'b0);
`ifdef WR_PACKER_TIMEOUT_EN
    for (int k = 1; k <= 17; k++) begin
      idle();
      check("to_winc", obs_winc, (k == 17));
      if (k == 17) check("to_wdata", obs_wdata, 32'h0000_005A);
    end
    idle();
    check("to_done", obs_winc, 0);
    check("to_busy", obs_busy, 0);
`else
    for (int k = 1; k <= 40; k++) begin
      idle();
      check("noto_winc", obs_winc, 0);
      check("noto_busy", obs_busy, 1);
    end
    send(8'h00, 1'b1);
    idle();
    check("noto_flush_winc", obs_winc, 1);
    check("noto_flush_wdata", obs_wdata, 32'h0000_005A);
    idle();
`endif

    // Random traffic against the packing model
    wrst_n = 1'b0;
    idle();
    wrst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      full    = ($urandom_range(0, 3) == 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 5) == 0);
      @(negedge wclk);
      if (!full) check("rnd_ready", s_ready, 1);
      if (full) check("rnd_no_winc_full", winc, 0);
      if (winc) begin
        check("rnd_word_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rnd_wdata", wdata, exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        cur_q.push_back(s_data);
        if (cur_q.size() == Ratio || s_last) begin
          word = '0;
          for (int i = 0; i < cur_q.size(); i++) word |= DataW'(cur_q[i]) << (InW * i);
          exp_q.push_back(word);
          cur_q.delete();
        end
      end
      @(posedge wclk);
      #1;
    end
    full    = 1'b0;
    s_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge wclk);
      if (winc) begin
        check("drain_word_pending", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("drain_wdata", wdata, exp_q.pop_front());
      end
      @(posedge wclk);
      #1;
    end
    check("rnd_all_written", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
